pcie_class_router: RTL and testbench

PCIE_CLASS_ROUTER -- requirements
Module: pcie_class_router

---
 rtl/pcie_class_router_pkg.sv | 18 +
 rtl/pcie_class_router_fifo_param.sv | 70 +++++++
 rtl/pcie_class_router.sv | 122 ++++++++++++
 tb/tb_pcie_class_router.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_class_router_pkg.sv
// Shared defaults and derived widths for the class router and its FIFOs.
package pcie_class_router_pkg;

  localparam int unsigned DEF_DATA_W = 12;
  localparam int unsigned DEF_NUM_CH = 4;
  localparam int unsigned DEF_DEPTH  = 8;
  localparam int unsigned DEF_AF_LVL = DEF_DEPTH - 2;
  localparam int unsigned DEF_AE_LVL = 1;
  localparam int unsigned DEF_CNT_W  = 5;

  localparam int unsigned CH_W  = $clog2(DEF_NUM_CH);
  localparam int unsigned PTR_W = $clog2(DEF_DEPTH);

  // Error vector layout: one bit per channel FIFO, input FIFO on top.
  localparam int unsigned ERR_CH0_IDX = 0;
  localparam int unsigned ERR_IN_IDX  = DEF_NUM_CH;

endpackage

// File: rtl/pcie_class_router_fifo_param.sv
// First-word-fall-through FIFO with programmable almost-full/empty levels
// and a sticky overflow/underflow error flag.
module fifo_param
  import pcie_class_router_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned AF_LVL = DEPTH - 2,
  parameter int unsigned AE_LVL = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              afull_o,
  output logic              empty_o,
  output logic              aempty_o,
  output logic              err_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = PW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]     occ_q, occ_d;
  logic              err_q, err_d;
  logic              do_push, do_pop;

  assign full_o   = (occ_q == OW'(DEPTH));
  assign empty_o  = (occ_q == '0);
  assign afull_o  = (occ_q >= OW'(AF_LVL));
  assign aempty_o = (occ_q <= OW'(AE_LVL));
  assign err_o    = err_q;
  assign data_o   = mem_q[rd_ptr_q];

  // Push is judged against full and pop against empty, both from the
  // current occupancy, so push+pop on empty and on full resolve correctly.
  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    occ_d    = occ_q + OW'(do_push) - OW'(do_pop);
    err_d    = err_q | (push_i & full_o) | (pop_i & empty_o);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/pcie_class_router.sv
// Routes words from one input FIFO to per-class channel FIFOs in order,
// with per-channel pop counters readable through a req/idx port.
module pcie_class_router
  import pcie_class_router_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned AF_LVL = DEPTH - 2,
  parameter int unsigned AE_LVL = DEF_AE_LVL,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_in,
  input  logic [DATA_W-1:0]          data_in,
  output logic                       full_in,
  output logic                       almost_full_in,
  input  logic [NUM_CH-1:0]          pop,
  output logic [NUM_CH*DATA_W-1:0]   data_out,
  output logic [NUM_CH-1:0]          empty,
  output logic [NUM_CH-1:0]          almost_empty,
  output logic [NUM_CH:0]            error,
  input  logic                       req,
  input  logic [$clog2(NUM_CH)-1:0]  idx,
  output logic [CNT_W-1:0]           cnt_data,
  output logic                       cnt_valid,
  output logic                       idle
);

  localparam int unsigned CHW = $clog2(NUM_CH);
  localparam int unsigned NF  = NUM_CH + 1;

  logic [NF-1:0]     f_push, f_pop, f_full, f_afull, f_empty, f_aempty, f_err;
  logic [DATA_W-1:0] f_wdata [NF];
  logic [DATA_W-1:0] f_rdata [NF];

  logic [DATA_W-1:0] head;
  logic [CHW-1:0]    head_cls;
  logic              fwd;

  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_data_q, cnt_data_d;
  logic              cnt_valid_q, cnt_valid_d;
  logic              unused_flags;

  assign head     = f_rdata[NUM_CH];
  assign head_cls = head[DATA_W-1 -: CHW];
  assign fwd      = !f_empty[NUM_CH] && !f_afull[head_cls];
  assign f_pop    = {fwd, pop};

  always_comb begin
    f_push = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      f_push[c]  = fwd && (head_cls == CHW'(c));
      f_wdata[c] = head;
    end
    f_push[NUM_CH]  = push_in;
    f_wdata[NUM_CH] = data_in;
  end

  // Instance NUM_CH is the input FIFO; 0..NUM_CH-1 are the channels.
  for (genvar i = 0; i < NF; i++) begin : g_fifo
    fifo_param #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AF_LVL (AF_LVL),
      .AE_LVL (AE_LVL)
    ) u_fifo (
      .clk_i    (clk),
      .rst_ni   (reset),
      .push_i   (f_push[i]),
      .pop_i    (f_pop[i]),
      .data_i   (f_wdata[i]),
      .data_o   (f_rdata[i]),
      .full_o   (f_full[i]),
      .afull_o  (f_afull[i]),
      .empty_o  (f_empty[i]),
      .aempty_o (f_aempty[i]),
      .err_o    (f_err[i])
    );
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_out
    assign data_out[c*DATA_W +: DATA_W] = f_rdata[c];
  end

  assign full_in        = f_full[NUM_CH];
  assign almost_full_in = f_afull[NUM_CH];
  assign empty          = f_empty[NUM_CH-1:0];
  assign almost_empty   = f_aempty[NUM_CH-1:0];
  assign error          = f_err;
  assign idle           = &f_empty;
  // Channel full never rises while the almost_full gate holds the forwarder.
  assign unused_flags   = ^{f_aempty[NUM_CH], f_full[NUM_CH-1:0]};

  // Readout samples cnt_q before this edge's increment.
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      cnt_d[c] = cnt_q[c] + CNT_W'(pop[c] & ~f_empty[c]);
    end
    cnt_data_d  = req ? cnt_q[idx] : cnt_data_q;
    cnt_valid_d = req;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned c = 0; c < NUM_CH; c++) cnt_q[c] <= '0;
      cnt_data_q  <= '0;
      cnt_valid_q <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) cnt_q[c] <= cnt_d[c];
      cnt_data_q  <= cnt_data_d;
      cnt_valid_q <= cnt_valid_d;
    end
  end

  assign cnt_data  = cnt_data_q;
  assign cnt_valid = cnt_valid_q;

endmodule

// File: tb/tb_pcie_class_router.sv
// Bench for pcie_class_router: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_pcie_class_router;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned AF_LVL = 6;
  localparam int unsigned AE_LVL = 1;
  localparam int unsigned CNT_W  = 5;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     push_in = 1'b0;
  logic [DATA_W-1:0]        data_in = '0;
  logic                     full_in, almost_full_in;
  logic [NUM_CH-1:0]        pop = '0;
  logic [NUM_CH*DATA_W-1:0] data_out;
  logic [NUM_CH-1:0]        empty, almost_empty;
  logic [NUM_CH:0]          error;
  logic                     req = 1'b0;
  logic [1:0]               idx = '0;
  logic [CNT_W-1:0]         cnt_data;
  logic                     cnt_valid, idle;

  pcie_class_router #(
    .DATA_W (DATA_W),
    .NUM_CH (NUM_CH),
    .DEPTH  (DEPTH),
    .AF_LVL (AF_LVL),
    .AE_LVL (AE_LVL),
    .CNT_W  (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .push_in        (push_in),
    .data_in        (data_in),
    .full_in        (full_in),
    .almost_full_in (almost_full_in),
    .pop            (pop),
    .data_out       (data_out),
    .empty          (empty),
    .almost_empty   (almost_empty),
    .error          (error),
    .req            (req),
    .idx            (idx),
    .cnt_data       (cnt_data),
    .cnt_valid      (cnt_valid),
    .idle           (idle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Reference model state
  logic [DATA_W-1:0] m_in [$];
  logic [DATA_W-1:0] m_ch [NUM_CH][$];
  logic [NUM_CH:0]   m_err;
  logic [CNT_W-1:0]  m_cnt [NUM_CH];
  logic [CNT_W-1:0]  m_cnt_data;
  logic              m_cnt_valid;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in.delete();
    for (int c = 0; c < NUM_CH; c++) begin
      m_ch[c].delete();
      m_cnt[c] = '0;
    end
    m_err       = '0;
    m_cnt_data  = '0;
    m_cnt_valid = 1'b0;
  endtask

  // One clock edge of the specified behaviour, all decisions from pre-edge state.
  task automatic model_step(input logic ps, input logic [DATA_W-1:0] d,
                            input logic [NUM_CH-1:0] p, input logic rq, input logic [1:0] ix);
    int unsigned in_sz = m_in.size();
    int unsigned ch_sz [NUM_CH];
    logic fwd = 1'b0;
    logic [DATA_W-1:0] hw = '0;
    logic [1:0] cls = '0;
    for (int c = 0; c < NUM_CH; c++) ch_sz[c] = m_ch[c].size();
    if (in_sz > 0) begin
      hw  = m_in[0];
      cls = hw[DATA_W-1 -: 2];
      fwd = (ch_sz[cls] < AF_LVL);
    end
    if (rq) begin
      m_cnt_data  = m_cnt[ix];
      m_cnt_valid = 1'b1;
    end else begin
      m_cnt_valid = 1'b0;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (p[c]) begin
        if (ch_sz[c] == 0) m_err[c] = 1'b1;
        else begin
          void'(m_ch[c].pop_front());
          m_cnt[c] = m_cnt[c] + 1'b1;
        end
      end
    end
    if (fwd) begin
      void'(m_in.pop_front());
      m_ch[cls].push_back(hw);
    end
    if (ps) begin
      if (in_sz == DEPTH) m_err[NUM_CH] = 1'b1;
      else m_in.push_back(d);
    end
  endtask

  task automatic compare_all();
    logic [NUM_CH-1:0] e_empty, e_ae;
    logic e_idle;
    e_idle = (m_in.size() == 0);
    for (int c = 0; c < NUM_CH; c++) begin
      e_empty[c] = (m_ch[c].size() == 0);
      e_ae[c]    = (m_ch[c].size() <= AE_LVL);
      if (m_ch[c].size() != 0) e_idle = 1'b0;
    end
    check("full_in", 64'(full_in), 64'(m_in.size() == DEPTH));
    check("almost_full_in", 64'(almost_full_in), 64'(m_in.size() >= AF_LVL));
    check("empty", 64'(empty), 64'(e_empty));
    check("almost_empty", 64'(almost_empty), 64'(e_ae));
    check("error", 64'(error), 64'(m_err));
    check("idle", 64'(idle), 64'(e_idle));
    check("cnt_valid", 64'(cnt_valid), 64'(m_cnt_valid));
    check("cnt_data", 64'(cnt_data), 64'(m_cnt_data));
    for (int c = 0; c < NUM_CH; c++)
      if (m_ch[c].size() != 0)
        check("data_out", 64'(data_out[c*DATA_W +: DATA_W]), 64'(m_ch[c][0]));
  endtask

  always @(negedge clk) if (chk_en) compare_all();

  task automatic step(input logic ps, input logic [DATA_W-1:0] d,
                      input logic [NUM_CH-1:0] p, input logic rq, input logic [1:0] ix);
    push_in = ps; data_in = d; pop = p; req = rq; idx = ix;
    @(posedge clk);
    model_step(ps, d, p, rq, ix);
    @(negedge clk);
    #1;
    push_in = 1'b0; pop = '0; req = 1'b0;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 2'd0);
  endtask

  function automatic logic [DATA_W-1:0] ch_word(input int c);
    return data_out[c*DATA_W +: DATA_W];
  endfunction

  // Asynchronous assert, reset values checked 1ns later, release on a falling edge.
  task automatic do_reset();
    reset  = 1'b0;
    chk_en = 1'b0;
    model_reset();
    #1;
    check("rst_empty", 64'(empty), 64'hF);
    check("rst_almost_empty", 64'(almost_empty), 64'hF);
    check("rst_full_in", 64'(full_in), 64'h0);
    check("rst_almost_full_in", 64'(almost_full_in), 64'h0);
    check("rst_idle", 64'(idle), 64'h1);
    check("rst_error", 64'(error), 64'h0);
    check("rst_cnt_valid", 64'(cnt_valid), 64'h0);
    check("rst_cnt_data", 64'(cnt_data), 64'h0);
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b1;
    chk_en = 1'b1;
    #1;
  endtask

  initial begin
    do_reset();

    // Four classes, one word each; two-edge latency on channel 0.
    step(1'b1, 12'h000, '0, 1'b0, 2'd0);
    check("lat_edge1_empty0", 64'(empty[0]), 64'h1);
    step(1'b1, 12'h401, '0, 1'b0, 2'd0);
    check("lat_edge2_empty0", 64'(empty[0]), 64'h0);
    check("idle_busy", 64'(idle), 64'h0);
    step(1'b1, 12'h802, '0, 1'b0, 2'd0);
    step(1'b1, 12'hC03, '0, 1'b0, 2'd0);
    idle_steps(1);
    check("route_empty", 64'(empty), 64'h0);
    check("route_ch0", 64'(ch_word(0)), 64'h000);
    check("route_ch1", 64'(ch_word(1)), 64'h401);
    check("route_ch2", 64'(ch_word(2)), 64'h802);
    check("route_ch3", 64'(ch_word(3)), 64'hC03);
    step(1'b0, '0, 4'hF, 1'b0, 2'd0);
    check("route_idle_back", 64'(idle), 64'h1);

    // Head-of-line blocking behind an almost-full channel 1.
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 12'h400 | 12'(i), '0, 1'b0, 2'd0);
    step(1'b1, 12'h0AA, '0, 1'b0, 2'd0);
    idle_steps(3);
    check("hol_blocked_empty0", 64'(empty[0]), 64'h1);
    check("hol_ch1_head", 64'(ch_word(1)), 64'h400);
    step(1'b0, '0, 4'b0010, 1'b0, 2'd0);
    idle_steps(1);
    check("hol_still_blocked", 64'(empty[0]), 64'h1);
    idle_steps(1);
    check("hol_released_empty0", 64'(empty[0]), 64'h0);
    check("hol_released_data", 64'(ch_word(0)), 64'h0AA);
    step(1'b0, '0, 4'b0011, 1'b0, 2'd0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 4'b0010, 1'b0, 2'd0);
    check("hol_drained_idle", 64'(idle), 64'h1);
    check("hol_no_error", 64'(error), 64'h0);

    // Input overflow while stalled; underflow on empty channel 2.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 12'h400 | 12'(i), '0, 1'b0, 2'd0);
    idle_steps(1);
    for (int i = 0; i < 9; i++) step(1'b1, 12'h500 | 12'(i), '0, 1'b0, 2'd0);
    check("ovf_full_in", 64'(full_in), 64'h1);
    check("ovf_error", 64'(error), 64'h10);
    step(1'b0, '0, 4'b0100, 1'b0, 2'd0);
    check("udf_error", 64'(error), 64'h14);
    check("udf_empty2", 64'(empty[2]), 64'h1);
    check("udf_ch1_head", 64'(ch_word(1)), 64'h400);

    // Counter wrap on channel 3 after 33 pops.
    do_reset();
    for (int i = 0; i < 33; i++) begin
      step(1'b1, 12'hC00 | 12'(i), '0, 1'b0, 2'd0);
      idle_steps(1);
      step(1'b0, '0, 4'b1000, 1'b0, 2'd0);
    end
    step(1'b0, '0, '0, 1'b1, 2'd3);
    check("wrap_cnt_data", 64'(cnt_data), 64'h1);
    check("wrap_cnt_valid", 64'(cnt_valid), 64'h1);
    idle_steps(1);
    check("wrap_valid_pulse", 64'(cnt_valid), 64'h0);
    check("wrap_data_hold", 64'(cnt_data), 64'h1);
    step(1'b0, '0, '0, 1'b1, 2'd0);
    check("ch0_cnt_zero", 64'(cnt_data), 64'h0);

    // Reset with words in flight, then a clean delivery.
    do_reset();
    step(1'b1, 12'h001, '0, 1'b0, 2'd0);
    step(1'b1, 12'h402, '0, 1'b0, 2'd0);
    step(1'b1, 12'h803, '0, 1'b0, 2'd0);
    step(1'b1, 12'hC04, '0, 1'b0, 2'd0);
    step(1'b1, 12'h005, '0, 1'b0, 2'd0);
    check("inflight_busy", 64'(idle), 64'h0);
    do_reset();
    step(1'b1, 12'h801, '0, 1'b0, 2'd0);
    check("post_rst_lat", 64'(empty), 64'hF);
    idle_steps(1);
    check("post_rst_empty", 64'(empty), 64'b1011);
    check("post_rst_ch2", 64'(ch_word(2)), 64'h801);

    // Random traffic at several pop intensities.
    do_reset();
    for (int ph = 0; ph < 4; ph++) begin
      for (int n = 0; n < 700; n++) begin
        logic [NUM_CH-1:0] p;
        for (int c = 0; c < NUM_CH; c++) p[c] = ($urandom_range(0, 3) < ph);
        step($urandom_range(0, 3) != 0, DATA_W'($urandom), p,
             $urandom_range(0, 3) == 0, 2'($urandom));
      end
      if (ph == 1) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
